imem_loader: RTL and testbench

- Writer side of the sISA instruction memory: accepts a program as a byte stream over a valid/ready handshake and stores it in a 16-entry instruction RAM.
- Keeps the CPU held in reset while loading, then releases it.
- Serves the CPU fetch port combinationally (address in, instruction out), so it drops in where the fixed ROM sits today.
- Lets the bench load different programs for golden-model comparison without recompiling.

---
 rtl/imem_loader_if.sv | 13 +
 rtl/imem_loader.sv | 107 ++++++++++
 tb/tb_imem_loader.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream program handshake feeding the instruction memory loader.
// The source drives valid/data/last and the loader answers with ready.
interface imem_loader_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;

  modport master (output in_valid, in_data, in_last, input in_ready);
  modport slave  (input in_valid, in_data, in_last, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// Loads a program byte stream into a small instruction RAM while holding the CPU in reset,
// then releases it. The fetch port is a combinational read, standing in for the fixed ROM.
module imem_loader #(
  parameter int                DEPTH     = 16,
  parameter int                ADDR_W    = 4,
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] FILL_WORD = 8'h40
) (
  input  logic              clk,
  input  logic              reset,
  imem_loader_if.slave      s_in,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              cpu_hold,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count,
  output logic [DATA_W-1:0] checksum,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_RUN
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_clrPtr;
  logic [ADDR_W:0]   r_wrPtr;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_sum;
  logic              r_done;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic w_accept;
  logic w_lastBeat;
  logic w_clearEnd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // A load ends on in_last or on the beat that fills the final location, whichever comes first.
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_lastBeat = 1'b0;
    w_clearEnd = 1'b0;
    case (r_state)
      S_IDLE:  if (load_start) w_next = S_CLEAR;
      S_CLEAR: begin
        w_clearEnd = (r_clrPtr == ADDR_W'(DEPTH - 1));
        if (w_clearEnd) w_next = S_LOAD;
      end
      S_LOAD: begin
        w_accept   = s_in.in_valid;
        w_lastBeat = w_accept & (s_in.in_last | (r_wrPtr == (ADDR_W + 1)'(DEPTH - 1)));
        if (w_lastBeat) w_next = S_RUN;
      end
      S_RUN:   if (load_start) w_next = S_CLEAR;
      default: w_next = S_IDLE;
    endcase
  end

  // load_count and checksum keep the previous load's results until the next load finishes,
  // except that the running checksum restarts at the CLEAR->LOAD transition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clrPtr <= '0;
      r_wrPtr  <= '0;
      r_count  <= '0;
      r_sum    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_lastBeat;
      if (r_state == S_CLEAR) r_clrPtr <= r_clrPtr + 1'b1;
      else                    r_clrPtr <= '0;
      if (w_clearEnd) begin
        r_wrPtr <= '0;
        r_sum   <= '0;
      end else if (w_accept) begin
        r_wrPtr <= r_wrPtr + 1'b1;
        r_sum   <= r_sum + s_in.in_data;
      end
      if (w_lastBeat) r_count <= r_wrPtr + 1'b1;
    end
  end

  // RAM is deliberately not reset; writes only happen in CLEAR or LOAD, never while reset holds IDLE.
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR)  r_mem[r_clrPtr] <= FILL_WORD;
    else if (w_accept)       r_mem[r_wrPtr[ADDR_W-1:0]] <= s_in.in_data;
  end

  assign fetch_instr   = r_mem[fetch_addr];
  assign s_in.in_ready = (r_state == S_LOAD);
  assign busy          = (r_state == S_CLEAR) || (r_state == S_LOAD);
  assign cpu_hold      = (r_state != S_RUN);
  assign load_done     = r_done;
  assign load_count    = r_count;
  assign checksum      = r_sum;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: scenario tasks plus randomized loads, all checked
// against an array-based model of what the RAM, count and checksum should hold.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load_start = 1'b0;
  logic [3:0] fetch_addr = '0;
  logic [7:0] fetch_instr;
  logic       cpu_hold;
  logic       load_done;
  logic [4:0] load_count;
  logic [7:0] checksum;
  logic       busy;

  imem_loader_if #(.DATA_W(8)) bus ();

  imem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .s_in       (bus),
    .load_start (load_start),
    .fetch_addr (fetch_addr),
    .fetch_instr(fetch_instr),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_count (load_count),
    .checksum   (checksum),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  logic [7:0] modelMem [16];
  int         modelCount;
  logic [7:0] modelSum;

  logic [7:0] progQ[$];
  bit         validPat[$];
  bit         useLast;
  bit         startInClear;
  bit         startInLoad;

  int   readyDelay, doneCount, holdBad;
  bit   timedOut;
  logic doneAtEnd, holdAtEnd, readyAtEnd, busyAtEnd, doneAfter;

  // Reference: every location gets the fill word, then the accepted program bytes from address 0.
  task automatic model_load();
    int sum = 0;
    for (int a = 0; a < 16; a++) modelMem[a] = 8'h40;
    modelCount = (progQ.size() > 16) ? 16 : progQ.size();
    for (int k = 0; k < modelCount; k++) begin
      modelMem[k] = progQ[k];
      sum = sum + int'(progQ[k]);
    end
    modelSum = 8'(sum % 256);
  endtask

  // Drives one load request and the program bytes, recording what it observed along the way.
  task automatic run_load();
    int  cyc = 0;
    int  idx = 0;
    int  pi = 0;
    bit  v;
    readyDelay = 0; doneCount = 0; holdBad = 0; timedOut = 0;
    @(negedge clk); load_start = 1'b1;
    @(negedge clk); load_start = 1'b0; readyDelay = 1; doneCount += int'(load_done);
    while (bus.in_ready !== 1'b1 && readyDelay < 100) begin
      if (cpu_hold !== 1'b1 || busy !== 1'b1) holdBad++;
      load_start = startInClear && (readyDelay == 5);
      @(negedge clk); readyDelay++; doneCount += int'(load_done);
    end
    load_start = 1'b0;
    if (readyDelay >= 100) begin
      timedOut = 1;
      return;
    end
    while (idx < progQ.size() && cyc < 300) begin
      v = (pi < validPat.size()) ? validPat[pi] : ($urandom_range(0, 3) != 0);
      pi++;
      if (cpu_hold !== 1'b1 || bus.in_ready !== 1'b1 || busy !== 1'b1) holdBad++;
      bus.in_valid = v;
      if (v) begin
        bus.in_data = progQ[idx];
        bus.in_last = useLast && (idx == progQ.size() - 1);
      end else begin
        bus.in_data = 8'($urandom);
        bus.in_last = 1'($urandom_range(0, 1));
      end
      load_start = startInLoad && v && (idx == 1);
      @(negedge clk); cyc++; doneCount += int'(load_done);
      if (v) idx++;
    end
    load_start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (cyc >= 300) timedOut = 1;
    doneAtEnd = load_done; holdAtEnd = cpu_hold; readyAtEnd = bus.in_ready; busyAtEnd = busy;
    @(negedge clk); doneAfter = load_done; doneCount += int'(load_done);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    compared++; if (cpu_hold !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_hold got=%b exp=1", cpu_hold); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    compared++; if (bus.in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ready got=%b exp=0", bus.in_ready); end
    compared++; if (load_done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done got=%b exp=0", load_done); end
    compared++; if (load_count !== 5'd0) begin mismatched++; $display("[TB] FAIL reset_count got=%0d exp=0", load_count); end
    compared++; if (checksum !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_sum got=%h exp=00", checksum); end
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    compared++; if (cpu_hold !== 1'b1 || busy !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_state hold=%b busy=%b exp hold=1 busy=0", cpu_hold, busy); end
  endtask

  task automatic test_basic_load();
    progQ = '{8'h81, 8'h92, 8'h13, 8'hC0}; validPat = '{1, 1, 1, 1}; useLast = 1;
    model_load();
    run_load();
    compared++; if (timedOut) begin mismatched++; $display("[TB] FAIL basic_timeout got=timeout exp=complete"); end
    compared++; if (readyDelay != 17) begin mismatched++; $display("[TB] FAIL basic_ready_delay got=%0d exp=17", readyDelay); end
    compared++; if (holdBad != 0) begin mismatched++; $display("[TB] FAIL basic_hold_during got=%0d bad cycles exp=0", holdBad); end
    compared++; if (doneAtEnd !== 1'b1 || holdAtEnd !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_end done=%b hold=%b exp done=1 hold=0", doneAtEnd, holdAtEnd); end
    compared++; if (readyAtEnd !== 1'b0 || busyAtEnd !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_end_ready ready=%b busy=%b exp 0 0", readyAtEnd, busyAtEnd); end
    compared++; if (doneAfter !== 1'b0 || doneCount != 1) begin mismatched++; $display("[TB] FAIL basic_done_pulse after=%b count=%0d exp 0 1", doneAfter, doneCount); end
    compared++; if (load_count !== 5'(modelCount)) begin mismatched++; $display("[TB] FAIL basic_count got=%0d exp=%0d", load_count, modelCount); end
    compared++; if (checksum !== modelSum) begin mismatched++; $display("[TB] FAIL basic_sum got=%h exp=%h", checksum, modelSum); end
    for (int a = 0; a < 16; a++) begin
      @(negedge clk); fetch_addr = 4'(a); #1;
      compared++; if (fetch_instr !== modelMem[a]) begin mismatched++; $display("[TB] FAIL basic_fetch addr=%0d got=%h exp=%h", a, fetch_instr, modelMem[a]); end
    end
  endtask

  task automatic test_full_load();
    progQ = {}; for (int k = 0; k < 16; k++) progQ.push_back(8'h10);
    validPat = '{}; for (int k = 0; k < 16; k++) validPat.push_back(1'b1);
    useLast = 0;
    model_load();
    run_load();
    compared++; if (timedOut || doneAtEnd !== 1'b1) begin mismatched++; $display("[TB] FAIL full_end timeout=%0d done=%b exp 0 1", timedOut, doneAtEnd); end
    compared++; if (load_count !== 5'd16) begin mismatched++; $display("[TB] FAIL full_count got=%0d exp=16", load_count); end
    compared++; if (checksum !== modelSum) begin mismatched++; $display("[TB] FAIL full_sum got=%h exp=%h", checksum, modelSum); end
    compared++; if (doneCount != 1) begin mismatched++; $display("[TB] FAIL full_done_count got=%0d exp=1", doneCount); end
    for (int a = 0; a < 16; a++) begin
      @(negedge clk); fetch_addr = 4'(a); #1;
      compared++; if (fetch_instr !== modelMem[a]) begin mismatched++; $display("[TB] FAIL full_fetch addr=%0d got=%h exp=%h", a, fetch_instr, modelMem[a]); end
    end
  endtask

  task automatic test_gaps();
    progQ = '{8'h81, 8'h92, 8'h13, 8'hC0}; validPat = '{1, 0, 0, 1, 0, 1, 1}; useLast = 1;
    model_load();
    run_load();
    compared++; if (timedOut || doneCount != 1) begin mismatched++; $display("[TB] FAIL gaps_done timeout=%0d count=%0d exp 0 1", timedOut, doneCount); end
    compared++; if (holdBad != 0) begin mismatched++; $display("[TB] FAIL gaps_ready_held got=%0d bad cycles exp=0", holdBad); end
    compared++; if (load_count !== 5'd4 || checksum !== modelSum) begin mismatched++; $display("[TB] FAIL gaps_result count=%0d sum=%h exp 4 %h", load_count, checksum, modelSum); end
    for (int a = 0; a < 16; a++) begin
      @(negedge clk); fetch_addr = 4'(a); #1;
      compared++; if (fetch_instr !== modelMem[a]) begin mismatched++; $display("[TB] FAIL gaps_fetch addr=%0d got=%h exp=%h", a, fetch_instr, modelMem[a]); end
    end
  endtask

  task automatic test_ignored_start();
    int extraDone = 0;
    progQ = '{8'h3C, 8'h5A, 8'hE1}; validPat = '{1, 1, 1}; useLast = 1;
    startInClear = 1; startInLoad = 1;
    model_load();
    run_load();
    startInClear = 0; startInLoad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); extraDone += int'(load_done);
    end
    compared++; if (readyDelay != 17) begin mismatched++; $display("[TB] FAIL ign_ready_delay got=%0d exp=17", readyDelay); end
    compared++; if (doneCount + extraDone != 1) begin mismatched++; $display("[TB] FAIL ign_done_total got=%0d exp=1", doneCount + extraDone); end
    compared++; if (busy !== 1'b0 || cpu_hold !== 1'b0) begin mismatched++; $display("[TB] FAIL ign_no_restart busy=%b hold=%b exp 0 0", busy, cpu_hold); end
    compared++; if (load_count !== 5'd3 || checksum !== modelSum) begin mismatched++; $display("[TB] FAIL ign_result count=%0d sum=%h exp 3 %h", load_count, checksum, modelSum); end
  endtask

  task automatic test_reload();
    compared++; if (cpu_hold !== 1'b0) begin mismatched++; $display("[TB] FAIL reload_run_hold got=%b exp=0", cpu_hold); end
    progQ = '{8'hA5}; validPat = '{1}; useLast = 1;
    model_load();
    run_load();
    compared++; if (timedOut || holdBad != 0) begin mismatched++; $display("[TB] FAIL reload_hold timeout=%0d bad=%0d exp 0 0", timedOut, holdBad); end
    compared++; if (doneAtEnd !== 1'b1 || holdAtEnd !== 1'b0) begin mismatched++; $display("[TB] FAIL reload_end done=%b hold=%b exp 1 0", doneAtEnd, holdAtEnd); end
    compared++; if (load_count !== 5'd1 || checksum !== 8'hA5) begin mismatched++; $display("[TB] FAIL reload_result count=%0d sum=%h exp 1 a5", load_count, checksum); end
    for (int a = 0; a < 16; a++) begin
      @(negedge clk); fetch_addr = 4'(a); #1;
      compared++; if (fetch_instr !== modelMem[a]) begin mismatched++; $display("[TB] FAIL reload_fetch addr=%0d got=%h exp=%h", a, fetch_instr, modelMem[a]); end
    end
  endtask

  task automatic test_reset_midload();
    int lateDone = 0;
    logic [4:0] prevCount;
    prevCount = load_count;
    progQ = '{8'h77, 8'h66}; validPat = '{1, 1}; useLast = 0;
    run_load();
    compared++; if (doneCount != 0 || busy !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_loading done=%0d busy=%b exp 0 1 (prev count %0d)", doneCount, busy, prevCount); end
    #2; reset = 1'b0; #1;
    compared++; if (busy !== 1'b0 || cpu_hold !== 1'b1 || bus.in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_reset busy=%b hold=%b ready=%b exp 0 1 0", busy, cpu_hold, bus.in_ready); end
    compared++; if (load_count !== 5'd0 || checksum !== 8'h00) begin mismatched++; $display("[TB] FAIL mid_reset_regs count=%0d sum=%h exp 0 00", load_count, checksum); end
    @(negedge clk); reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); lateDone += int'(load_done);
    end
    compared++; if (lateDone != 0 || cpu_hold !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_idle done=%0d hold=%b exp 0 1", lateDone, cpu_hold); end
    progQ = '{8'h81, 8'h92, 8'h13, 8'hC0}; validPat = '{1, 1, 1, 1}; useLast = 1;
    model_load();
    run_load();
    compared++; if (readyDelay != 17 || doneCount != 1) begin mismatched++; $display("[TB] FAIL mid_reload delay=%0d done=%0d exp 17 1", readyDelay, doneCount); end
    compared++; if (load_count !== 5'd4 || checksum !== modelSum) begin mismatched++; $display("[TB] FAIL mid_reload_result count=%0d sum=%h exp 4 %h", load_count, checksum, modelSum); end
    for (int a = 0; a < 16; a++) begin
      @(negedge clk); fetch_addr = 4'(a); #1;
      compared++; if (fetch_instr !== modelMem[a]) begin mismatched++; $display("[TB] FAIL mid_fetch addr=%0d got=%h exp=%h", a, fetch_instr, modelMem[a]); end
    end
  endtask

  task automatic test_random();
    int n;
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 16);
      progQ = {};
      for (int k = 0; k < n; k++) progQ.push_back(8'($urandom));
      validPat = '{};
      useLast = (n < 16) ? 1'b1 : 1'($urandom_range(0, 1));
      model_load();
      run_load();
      compared++; if (timedOut || doneCount != 1) begin mismatched++; $display("[TB] FAIL rand_done iter=%0d timeout=%0d count=%0d exp 0 1", t, timedOut, doneCount); end
      compared++; if (load_count !== 5'(modelCount)) begin mismatched++; $display("[TB] FAIL rand_count iter=%0d got=%0d exp=%0d", t, load_count, modelCount); end
      compared++; if (checksum !== modelSum) begin mismatched++; $display("[TB] FAIL rand_sum iter=%0d got=%h exp=%h", t, checksum, modelSum); end
      for (int a = 0; a < 16; a++) begin
        @(negedge clk); fetch_addr = 4'(a); #1;
        compared++; if (fetch_instr !== modelMem[a]) begin mismatched++; $display("[TB] FAIL rand_fetch iter=%0d addr=%0d got=%h exp=%h", t, a, fetch_instr, modelMem[a]); end
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    startInClear = 0;
    startInLoad  = 0;
    test_reset();
    test_basic_load();
    test_full_load();
    test_gaps();
    test_ignored_start();
    test_reload();
    test_reset_midload();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout exp=bench complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
